convolution_output: RTL and testbench

//  Back end of the 5x5 convolution path. Accepts raw MAC accumulator results
//  (one per valid cycle, raster order) for a 24x24 output map (28x28 image, 5x5 kernel).

---
 rtl/convolution_output.sv | 167 ++++++++++++++++
 tb/tb_convolution_output.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/convolution_output.sv
// Back end of the 5x5 convolution path: scales, ReLUs and saturates MAC results,
// tags them with raster row/col, and streams them out through a small FWFT FIFO.
module convolution_output #(
    parameter int I_W        = 20,
    parameter int O_W        = 8,
    parameter int SHIFT      = 4,
    parameter int OUT_W      = 24,
    parameter int OUT_H      = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [I_W-1:0] i_acc,
    input  logic           i_valid,
    output logic           o_ready,
    output logic [O_W-1:0] o_data,
    output logic [4:0]     o_row,
    output logic [4:0]     o_col,
    output logic           o_last,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic           o_err,
    output logic [1:0]     dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = O_W + 5 + 5 + 1;

    // Both sides use the same handshake: a transfer happens on a rising edge where
    // valid and ready are both high; the sender holds its payload until then.

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t          state;
    logic [4:0]      row;
    logic [4:0]      col;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            full;
    logic            push;
    logic            pop;
    logic            at_last_col;
    logic            at_last_pix;
    logic [O_W-1:0]  pix;
    logic [EW-1:0]   head;
    logic signed [I_W-1:0] shifted;

    assign shifted = $signed(i_acc) >>> SHIFT;

    always_comb begin
        pix = '0;
        if (shifted[I_W-1])
            pix = '0;
        else if (|shifted[I_W-2:O_W])
            pix = '1;
        else
            pix = shifted[O_W-1:0];
    end

    assign at_last_col = (col == 5'(OUT_W - 1));
    assign at_last_pix = at_last_col && (row == 5'(OUT_H - 1));
    assign o_ready     = (state == COLLECT) && !full;
    assign push        = i_valid && o_ready;
    assign pop         = o_valid && i_ready;
    assign dbg_state   = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_err  <= 1'b0;
                        row    <= '0;
                        col    <= '0;
                        o_busy <= 1'b1;
                        state  <= COLLECT;
                    end else if (i_valid) begin
                        o_err <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A stalled i_valid here is back-pressure, not a protocol error.
                    if (push) begin
                        if (at_last_pix) begin
                            row   <= '0;
                            col   <= '0;
                            state <= DRAIN;
                        end else if (at_last_col) begin
                            col <= '0;
                            row <= row + 5'd1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_valid)
                        o_err <= 1'b1;
                    if (count == '0) begin
                        o_frame_done <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (i_valid)
                        o_err <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW + 1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= {pix, row, col, at_last_pix};
    end

    // Payload is forced to zero whenever the FIFO is empty so reset leaves all outputs low.
    assign head    = mem[rd_ptr];
    assign o_valid = (count != '0);
    assign o_data  = o_valid ? head[EW-1 -: O_W] : '0;
    assign o_row   = o_valid ? head[10:6] : '0;
    assign o_col   = o_valid ? head[5:1] : '0;
    assign o_last  = o_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_convolution_output.sv
// Directed bench for convolution_output: frame streaming, pixel arithmetic,
// back-pressure, error flag, mid-frame reset and ignored restart.
module tb_convolution_output;

  localparam int N = 576;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] acc;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data;
  logic [4:0]  row;
  logic [4:0]  col;
  logic        last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int frame_done_cnt = 0;
  int acc_total = 0;
  int pop_total = 0;
  int log_idx = 0;
  int rdy_mode = 0;
  logic [7:0] out_log [4];
  logic [9:0] first_rc;
  logic [9:0] last_rc;
  logic [18:0] exp_q [$];

  convolution_output dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_acc(acc), .i_valid(in_valid),
    .o_ready(in_ready), .o_data(data), .o_row(row), .o_col(col), .o_last(last),
    .o_valid(out_valid), .i_ready(out_ready), .o_busy(busy),
    .o_frame_done(frame_done), .o_err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model
  function automatic logic [19:0] acc_of(input int idx);
    int t;
    case (idx)
      0: return 20'hFFF9C;
      1: return 20'h00FFF;
      2: return 20'h000A0;
      3: return 20'h00FF0;
      4: return 20'h80000;
      5: return 20'h7FFFF;
      6: return 20'h0000F;
      7: return 20'hFFFFF;
      8: return 20'h01000;
      default: begin
        t = idx * 16 - 1000;
        return t[19:0];
      end
    endcase
  endfunction

  function automatic logic [7:0] model_pix(input logic [19:0] a);
    int s;
    int q;
    s = $signed(a);
    if (s < 0) return 8'd0;
    q = s / 16;
    if (q > 255) return 8'd255;
    return q[7:0];
  endfunction

  function automatic logic [18:0] model_entry(input int idx);
    return {model_pix(acc_of(idx)), 5'(idx / 24), 5'(idx % 24), idx == N - 1};
  endfunction

  // ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_total++;
      if (frame_done) frame_done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_without_expect", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_entry", {13'd0, data, row, col, last}, {13'd0, exp_q[0]});
          if (out_ready) begin
            if (log_idx == 0) first_rc = {row, col};
            if (log_idx < 4) out_log[log_idx] = data;
            log_idx++;
            if (last) last_rc = {row, col};
            void'(exp_q.pop_front());
            pop_total++;
          end
        end
      end
    end
  end

  // drivers
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int first, input int n, input int start_at);
    int t;
    bit got;
    for (int k = first; k < first + n; k++) begin
      in_valid = 1'b1;
      acc = acc_of(k);
      if (k == start_at) start = 1'b1;
      t = 0;
      got = 0;
      while (!got && t < 300) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1;
          exp_q.push_back(model_entry(k));
        end
        @(posedge clk); #1;
        start = 1'b0;
        t++;
      end
      if (!got) begin
        failures++;
        $display("FAIL accept_timeout: sample %0d not accepted", k);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target, input int pops_before);
    int t;
    t = 0;
    while (frame_done_cnt < target && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (frame_done_cnt < target) begin
      failures++;
      $display("FAIL frame_done_timeout: count %0d expected %0d", frame_done_cnt, target);
    end
    repeat (3) @(negedge clk);
    chk("frame_done_once", frame_done_cnt, target);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("fifo_drained", exp_q.size(), 0);
    chk("pops_per_frame", pop_total - pops_before, N);
    chk("last_tag", {22'd0, last_rc}, {22'd0, 5'd23, 5'd23});
  endtask

  initial begin
    int fd_base;
    int pop_base;
    int acc_base;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; acc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_data", {24'd0, data}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // stray valid while idle
    in_valid = 1'b1; acc = 20'h00100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_idle", {31'd0, err}, 1);
    chk("no_write_idle", {31'd0, out_valid}, 0);
    @(posedge clk); #1;

    // full frame, ready always high
    pulse_start();
    @(negedge clk);
    chk("err_cleared", {31'd0, err}, 0);
    chk("busy_set", {31'd0, busy}, 1);
    chk("ready_up", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    log_idx = 0; fd_base = frame_done_cnt; pop_base = pop_total;
    send(0, N, -1);
    wait_frame(fd_base + 1, pop_base);
    chk("pix0_neg", {24'd0, out_log[0]}, 0);
    chk("pix1_sat", {24'd0, out_log[1]}, 255);
    chk("pix2_mid", {24'd0, out_log[2]}, 10);
    chk("pix3_sat", {24'd0, out_log[3]}, 255);
    chk("first_tag", {22'd0, first_rc}, 0);

    // downstream stalled for 20+ cycles
    rdy_mode = 1;
    @(posedge clk); #1;
    pulse_start();
    fd_base = frame_done_cnt; pop_base = pop_total; acc_base = acc_total;
    fork
      send(0, N, -1);
      begin
        repeat (22) @(negedge clk);
        chk("accepts_until_full", acc_total - acc_base, 16);
        chk("ready_low_full", {31'd0, in_ready}, 0);
        chk("valid_while_stalled", {31'd0, out_valid}, 1);
        rdy_mode = 0;
      end
    join
    wait_frame(fd_base + 1, pop_base);
    chk("no_err_on_stall", {31'd0, err}, 0);

    // reset mid-frame after 300 accepted pixels
    pulse_start();
    send(0, 300, -1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_ready", {31'd0, in_ready}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_data", {24'd0, data}, 0);
    chk("midrst_tags", {21'd0, row, col, last}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // fresh frame, random ready, restart pulse ignored mid-frame
    rdy_mode = 2;
    pulse_start();
    log_idx = 0; fd_base = frame_done_cnt; pop_base = pop_total;
    send(0, N, 100);
    chk("busy_during_frame", {31'd0, busy}, 1);
    rdy_mode = 0;
    wait_frame(fd_base + 1, pop_base);
    chk("restart_first_tag", {22'd0, first_rc}, 0);
    chk("no_err_restart", {31'd0, err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
